// File: rtl/loader_pkg.sv
// Shared types, constants and helpers for the UART instruction-memory loader.
package loader_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        L_LEN_LO,
        L_LEN_HI,
        L_DATA,
        L_DONE,
        L_ERR
    } ld_state_t;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_W          = HDR_BYTES * 8;

    // Little-endian assembly: drop byte b into lane position of word w.
    function automatic logic [31:0] put_lane(input logic [31:0] w,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port driven by the loader.
interface imem_uart_loader_if #(
    parameter int unsigned ADDR_W = 8
) ();

    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (output imem_we, output imem_addr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop rx synchroniser, mid-bit sampling,
// one-cycle byte_valid or frame_err_pulse per received frame.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err_pulse
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_rx_meta;
    logic             r_rx_sync;
    rx_state_t        r_state;
    rx_state_t        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_byte_valid;
    logic [7:0]       r_byte_data;
    logic             r_frame_err;
    logic             w_half_tick;
    logic             w_full_tick;
    logic             w_valid_d;
    logic             w_ferr_d;

    assign w_half_tick = (r_cnt == HALF_M1);
    assign w_full_tick = (r_cnt == FULL_M1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            R_IDLE:  if (!r_rx_sync) w_next = R_START;
            // A start bit that is gone by mid-bit is treated as a glitch.
            R_START: if (w_half_tick) w_next = r_rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (w_full_tick && (r_bit_idx == 3'd7)) w_next = R_STOP;
            R_STOP:  if (w_full_tick) w_next = R_IDLE;
            default: w_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_valid_d = 1'b0;
        w_ferr_d  = 1'b0;
        if ((r_state == R_STOP) && w_full_tick) begin
            w_valid_d = r_rx_sync;
            w_ferr_d  = !r_rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= w_valid_d;
            r_frame_err  <= w_ferr_d;
            if (w_valid_d) r_byte_data <= r_shift;

            if ((r_state == R_IDLE) || (w_next != r_state) || w_full_tick) r_cnt <= '0;
            else                                                          r_cnt <= r_cnt + CNT_W'(1);

            if ((r_state == R_DATA) && w_full_tick) begin
                r_shift   <= {r_rx_sync, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end else if (r_state != R_DATA) begin
                r_bit_idx <= '0;
            end
        end
    end

    assign o_byte_valid      = r_byte_valid;
    assign o_byte_data       = r_byte_data;
    assign o_frame_err_pulse = r_frame_err;

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: parses a length-prefixed UART image, writes it into
// instruction memory and holds the core in reset until the image is complete.
module imem_uart_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    imem_uart_loader_if.master imem,
    output logic               core_reset,
    output logic               load_done,
    output logic               frame_err,
    output logic               len_err,
    output logic [ADDR_W:0]    word_count
);

    localparam int unsigned MAX_WORDS = 2 ** ADDR_W;
    localparam int unsigned LENX_W    = LEN_W + 1;
    localparam int unsigned WC_W      = ADDR_W + 1;
    localparam logic [LENX_W-1:0] MAX_WORDS_X = LENX_W'(MAX_WORDS);
    localparam logic [1:0]        LAST_LANE   = 2'(BYTES_PER_WORD - 1);

    logic              w_byte_valid;
    logic [7:0]        w_byte_data;
    logic              w_frame_err_pulse;

    ld_state_t         r_ld_state;
    ld_state_t         w_ld_next;
    logic [LEN_W-1:0]  r_len;
    logic [1:0]        r_lane;
    logic [ADDR_W-1:0] r_widx;
    logic [31:0]       r_wbuf;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_imem_wdata;
    logic              r_core_reset;
    logic              r_load_done;
    logic              r_frame_err;
    logic              r_len_err;
    logic [ADDR_W:0]   r_word_count;

    logic [LEN_W-1:0]  w_len_full;
    logic              w_len_zero;
    logic              w_len_bad;
    logic              w_word_done;
    logic              w_last_word;
    logic              w_we_d;
    logic              w_core_reset_d;
    logic              w_load_done_d;
    logic              w_frame_err_set;
    logic              w_len_err_set;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk              (clk),
        .reset            (reset),
        .i_rx             (rx),
        .o_byte_valid     (w_byte_valid),
        .o_byte_data      (w_byte_data),
        .o_frame_err_pulse(w_frame_err_pulse)
    );

    assign w_len_full  = {w_byte_data, r_len[7:0]};
    assign w_len_zero  = (w_len_full == '0);
    assign w_len_bad   = ({1'b0, w_len_full} > MAX_WORDS_X);
    assign w_word_done = w_byte_valid && (r_ld_state == L_DATA) && (r_lane == LAST_LANE);
    assign w_last_word = ((LENX_W'(r_widx) + LENX_W'(1)) == {1'b0, r_len});

    always_ff @(posedge clk) begin
        if (reset) r_ld_state <= L_LEN_LO;
        else       r_ld_state <= w_ld_next;
    end

    always_comb begin
        w_ld_next = r_ld_state;
        case (r_ld_state)
            L_LEN_LO: begin
                if (w_frame_err_pulse) w_ld_next = L_ERR;
                else if (w_byte_valid) w_ld_next = L_LEN_HI;
            end
            L_LEN_HI: begin
                if (w_frame_err_pulse) w_ld_next = L_ERR;
                else if (w_byte_valid) begin
                    if (w_len_zero)     w_ld_next = L_DONE;
                    else if (w_len_bad) w_ld_next = L_ERR;
                    else                w_ld_next = L_DATA;
                end
            end
            L_DATA: begin
                if (w_frame_err_pulse)            w_ld_next = L_ERR;
                else if (w_word_done && w_last_word) w_ld_next = L_DONE;
            end
            L_DONE:  w_ld_next = L_DONE;
            L_ERR:   w_ld_next = L_ERR;
            default: w_ld_next = L_ERR;
        endcase
    end

    // core_reset is held through the final write strobe and drops one cycle later.
    always_comb begin
        w_we_d          = w_word_done;
        w_core_reset_d  = (w_ld_next != L_DONE) || w_we_d;
        w_load_done_d   = !w_core_reset_d;
        w_frame_err_set = w_frame_err_pulse &&
                          ((r_ld_state == L_LEN_LO) || (r_ld_state == L_LEN_HI) ||
                           (r_ld_state == L_DATA));
        w_len_err_set   = (r_ld_state == L_LEN_HI) && w_byte_valid && !w_len_zero && w_len_bad;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len        <= '0;
            r_lane       <= '0;
            r_widx       <= '0;
            r_wbuf       <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_core_reset <= 1'b1;
            r_load_done  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_len_err    <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_imem_we    <= w_we_d;
            r_core_reset <= w_core_reset_d;
            r_load_done  <= w_load_done_d;
            if (w_frame_err_set) r_frame_err <= 1'b1;
            if (w_len_err_set)   r_len_err   <= 1'b1;

            if ((r_ld_state == L_LEN_LO) && w_byte_valid) r_len[7:0] <= w_byte_data;

            if ((r_ld_state == L_LEN_HI) && w_byte_valid) begin
                r_len  <= w_len_full;
                r_lane <= '0;
                r_widx <= '0;
            end

            if ((r_ld_state == L_DATA) && w_byte_valid) begin
                r_wbuf <= put_lane(r_wbuf, r_lane, w_byte_data);
                r_lane <= r_lane + 2'd1;
            end

            if (w_we_d) begin
                r_imem_addr  <= r_widx;
                r_imem_wdata <= put_lane(r_wbuf, r_lane, w_byte_data);
                r_widx       <= r_widx + ADDR_W'(1);
                r_word_count <= r_word_count + WC_W'(1);
            end
        end
    end

    assign imem.imem_we    = r_imem_we;
    assign imem.imem_addr  = r_imem_addr;
    assign imem.imem_wdata = r_imem_wdata;
    assign core_reset      = r_core_reset;
    assign load_done       = r_load_done;
    assign frame_err       = r_frame_err;
    assign len_err         = r_len_err;
    assign word_count      = r_word_count;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Scoreboard bench for imem_uart_loader: image-level reference model feeds
// expected writes to a queue, an independent monitor checks every strobe.
module tb_imem_uart_loader;

    localparam int unsigned CPB = 4;
    localparam int unsigned AW  = 8;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic          core_reset;
    logic          load_done;
    logic          frame_err;
    logic          len_err;
    logic [AW:0]   word_count;

    imem_uart_loader_if #(.ADDR_W(AW)) imem_bus ();

    imem_uart_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .imem      (imem_bus),
        .core_reset(core_reset),
        .load_done (load_done),
        .frame_err (frame_err),
        .len_err   (len_err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int  total = 0;
    int  bad   = 0;
    wr_t exp_q[$];
    bit  img_has_words = 1'b0;
    bit  prev_we = 1'b0;
    bit  prev_cr = 1'b1;
    int  byte_pulses = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(posedge clk) if (dut.w_byte_valid) byte_pulses++;

    // Monitor: every write strobe is matched against the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (reset) begin
            prev_we = 1'b0;
            prev_cr = 1'b1;
        end else begin
            if (imem_bus.imem_we) begin
                check("we_while_core_reset", 64'(core_reset), 64'(1));
                check("we_not_back_to_back", 64'(prev_we), 64'(0));
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr=%0h data=%0h required=none",
                             imem_bus.imem_addr, imem_bus.imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(imem_bus.imem_addr), 64'(e.addr));
                    check("wr_data", 64'(imem_bus.imem_wdata), 64'(e.data));
                end
            end
            if (prev_cr && !core_reset)
                check("core_reset_fall_after_last_we", 64'(prev_we), 64'(img_has_words));
            prev_we = imem_bus.imem_we;
            prev_cr = core_reset;
        end
    end

    // Reference model: parse the image as a whole from the byte list.
    task automatic run_model(input bq_t b, input int bad_idx,
                             output logic e_done, output logic e_ferr,
                             output logic e_lerr, output int e_words);
        int  ok;
        int  n;
        int  avail;
        wr_t t;
        ok      = (bad_idx < 0) ? b.size() : bad_idx;
        e_done  = 1'b0;
        e_ferr  = 1'b0;
        e_lerr  = 1'b0;
        e_words = 0;
        if (ok < 2) begin
            e_ferr = (bad_idx >= 0);
            return;
        end
        n = int'(b[0]) + 256 * int'(b[1]);
        if (n == 0) begin
            e_done = 1'b1;
        end else if (n > 2 ** AW) begin
            e_lerr = 1'b1;
        end else begin
            avail = (ok - 2) / 4;
            if (avail > n) avail = n;
            for (int w = 0; w < avail; w++) begin
                t.addr = AW'(w);
                t.data = {b[2+4*w+3], b[2+4*w+2], b[2+4*w+1], b[2+4*w]};
                exp_q.push_back(t);
            end
            e_words = avail;
            if (avail == n)        e_done = 1'b1;
            else if (bad_idx >= 0) e_ferr = 1'b1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(v[i]);
        drive_bit(stop_ok);
        if (!stop_ok) drive_bit(1'b1);
    endtask

    task automatic send_stream(input bq_t b, input int bad_idx);
        for (int i = 0; i < b.size(); i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(b[i], i != bad_idx);
        end
    endtask

    task automatic begin_test();
        @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rst/imem_we",    64'(imem_bus.imem_we),    64'(0));
        check("rst/imem_addr",  64'(imem_bus.imem_addr),  64'(0));
        check("rst/imem_wdata", 64'(imem_bus.imem_wdata), 64'(0));
        check("rst/word_count", 64'(word_count),          64'(0));
        check("rst/core_reset", 64'(core_reset),          64'(1));
        check("rst/load_done",  64'(load_done),           64'(0));
        check("rst/frame_err",  64'(frame_err),           64'(0));
        check("rst/len_err",    64'(len_err),             64'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic load_and_check(input string nm, input bq_t b, input int bad_idx);
        logic e_done, e_ferr, e_lerr;
        int   e_words;
        int   waited;
        run_model(b, bad_idx, e_done, e_ferr, e_lerr, e_words);
        img_has_words = (e_words > 0);
        send_stream(b, bad_idx);
        if (e_done) begin
            waited = 0;
            while (core_reset && waited < 8) begin
                @(negedge clk);
                waited++;
            end
            check({nm, "/release_latency_ok"}, 64'(waited <= 3), 64'(1));
        end
        repeat (3 * CPB) @(negedge clk);
        check({nm, "/core_reset"},     64'(core_reset),   64'(!e_done));
        check({nm, "/load_done"},      64'(load_done),    64'(e_done));
        check({nm, "/frame_err"},      64'(frame_err),    64'(e_ferr));
        check({nm, "/len_err"},        64'(len_err),      64'(e_lerr));
        check({nm, "/word_count"},     64'(word_count),   64'(e_words));
        check({nm, "/pending_writes"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bq_t b;
        int  n;
        int  snap;
        reset = 1'b1;
        rx    = 1'b1;

        begin_test();
        b = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        load_and_check("two_word", b, -1);

        begin_test();
        b = '{8'h00, 8'h00};
        load_and_check("empty", b, -1);

        begin_test();
        b = '{8'h01, 8'h00, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44};
        load_and_check("frame_err", b, 2);

        begin_test();
        b = '{8'h01, 8'h01, 8'(19), 8'h00, 8'h00, 8'h00};
        load_and_check("len_err", b, -1);

        begin_test();
        b = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        img_has_words = 1'b0;
        send_stream(b, -1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_mid/word_count", 64'(word_count), 64'(0));
        b = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        load_and_check("reset_mid", b, -1);

        begin_test();
        snap = byte_pulses;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check("glitch/no_byte", 64'(byte_pulses - snap), 64'(0));
        b = '{8'h02, 8'h00};
        for (int i = 0; i < 8; i++) b.push_back(8'($urandom_range(0, 255)));
        load_and_check("glitch_then_load", b, -1);

        for (int it = 0; it < 3; it++) begin
            begin_test();
            n = $urandom_range(1, 6);
            b = '{8'(n), 8'h00};
            for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom_range(0, 255)));
            load_and_check("random", b, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
